// File: rtl/piso_shift_register_pkg.sv
// Shared definitions for the parallel-in / serial-out shift register.
package piso_shift_register_pkg;

    localparam int unsigned PISO_DEFAULT_WIDTH = 8;

    typedef enum logic {
        PISO_MODE_SHIFT = 1'b0,
        PISO_MODE_LOAD  = 1'b1
    } piso_mode_t;

endpackage : piso_shift_register_pkg

// File: rtl/piso_shift_register.sv
// Parallel-in / serial-out shift register, LSB first, with serial fill into the MSB.
// Define PISO_SHIFT_REGISTER_PAROUT_EN to expose the full register on parallelOut.
module piso_shift_register
    import piso_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallelIn,
    input  logic             serialIn,
    input  logic             mode,
`ifdef PISO_SHIFT_REGISTER_PAROUT_EN
    output logic [WIDTH-1:0] parallelOut,
`endif
    output logic             serialOut
);

    logic [WIDTH-1:0] r_sr;
    piso_mode_t       w_mode;

    assign w_mode = piso_mode_t'(mode);

    // Load replaces the whole word; shift drops bit 0 and fills the MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr <= '0;
        end else if (w_mode == PISO_MODE_LOAD) begin
            r_sr <= parallelIn;
        end else begin
            r_sr <= {serialIn, r_sr[WIDTH-1:1]};
        end
    end

    assign serialOut = r_sr[0];

`ifdef PISO_SHIFT_REGISTER_PAROUT_EN
    assign parallelOut = r_sr;
`endif

endmodule : piso_shift_register

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench for piso_shift_register: bit-queue reference model, decoupled monitor.
module tb_piso_shift_register;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] parallelIn;
    logic         serialIn;
    logic         mode;
    logic         serialOut;
`ifdef PISO_SHIFT_REGISTER_PAROUT_EN
    logic [W-1:0] parallelOut;
`endif

    piso_shift_register #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .parallelIn (parallelIn),
        .serialIn   (serialIn),
        .mode       (mode),
`ifdef PISO_SHIFT_REGISTER_PAROUT_EN
        .parallelOut(parallelOut),
`endif
        .serialOut  (serialOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         so;
        logic [W-1:0] po;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    bit   model_q[$];   // bits in the order they will leave on serialOut
    int   n_checks = 0;
    int   n_pass   = 0;
    string cur_tag = "reset";

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic logic [W-1:0] model_word();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(W); i++) v[i] = model_q[i];
        return v;
    endfunction

    task automatic model_clear();
        model_q.delete();
        for (int i = 0; i < int'(W); i++) model_q.push_back(1'b0);
    endtask

    // Drive one cycle's inputs at the falling edge and predict the state after the next rising edge.
    task automatic drive(input logic rst_v, input logic m, input logic [W-1:0] p, input logic s);
        exp_t e;
        @(negedge clk);
        reset      = rst_v;
        mode       = m;
        parallelIn = p;
        serialIn   = s;
        if (!rst_v) begin
            model_clear();
        end else if (m) begin
            model_q.delete();
            for (int i = 0; i < int'(W); i++) model_q.push_back(p[i]);
        end else begin
            void'(model_q.pop_front());
            model_q.push_back(s);
        end
        e.so  = model_q[0];
        e.po  = model_word();
        e.tag = cur_tag;
        exp_q.push_back(e);
    endtask

    // Assert reset between edges and confirm the clear needs no clock.
    task automatic async_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check({cur_tag, "_async_so"}, W'(serialOut), '0);
`ifdef PISO_SHIFT_REGISTER_PAROUT_EN
        check({cur_tag, "_async_po"}, parallelOut, '0);
`endif
    endtask

    // Monitor: the register presents a new value after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, "_so"}, W'(serialOut), W'(e.so));
`ifdef PISO_SHIFT_REGISTER_PAROUT_EN
                check({e.tag, "_po"}, parallelOut, e.po);
`endif
            end
        end
    end

    initial begin
        int wait_cycles;
        reset = 1'b0; mode = 1'b1; parallelIn = 8'hFF; serialIn = 1'b1;
        model_clear();

        cur_tag = "reset_hold";
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'hFF, 1'b1);

        cur_tag = "load9";
        drive(1'b1, 1'b1, 8'd9, 1'b0);
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);

        cur_tag = "load28";
        drive(1'b1, 1'b1, 8'd28, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);

        cur_tag = "fill";
        async_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        begin
            logic [W-1:0] fill;
            fill = 8'h4D;
            for (int i = 0; i < int'(W); i++) drive(1'b1, 1'b0, 8'h00, fill[i]);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);

        cur_tag = "mid_reset";
        drive(1'b1, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
        async_reset();
        drive(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);

        cur_tag = "reload";
        drive(1'b1, 1'b1, 8'h0F, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'hF0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);

        cur_tag = "track";
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'($urandom), 1'b0);

        cur_tag = "random";
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                  8'($urandom), 1'($urandom));

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_piso_shift_register
